// File: rtl/pattern_tx_pkg.sv
// pattern_tx shared types: FSM state enum, default widths, counter sizing.
// Optional parity feature is selected with PATTERN_TX_PARITY_EN.
package pattern_tx_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    GAP
  } state_t;

  function automatic int bit_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_tx_shifter.sv
// Rotating pattern register with bit counter; flags the last bit of an
// instance and leaves the pattern restored for the next instance.
module pattern_tx_shifter
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  output logic             msb,
  output logic             next_bit,
  output logic             last
);

  localparam int BW = bit_cnt_w(PAT_W);

  logic [PAT_W-1:0] sreg;
  logic [BW-1:0]    bcnt;

  // rotate rather than shift: after PAT_W bits the pattern is back in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bcnt <= '0;
    end else if (load) begin
      sreg <= pattern;
      bcnt <= '0;
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], sreg[PAT_W-1]};
      bcnt <= last ? '0 : bcnt + BW'(1);
    end
  end

  assign msb      = sreg[PAT_W-1];
  assign next_bit = sreg[PAT_W-2];
  assign last     = (bcnt == BW'(PAT_W - 1));

endmodule

// File: rtl/pattern_tx.sv
// Bit-serial pattern transmitter, MSB first, N repeats with idle gaps.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit per instance.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PAT_W-1:0] req_pattern,
  input  logic [CNT_W-1:0] req_repeat,
  input  logic [GAP_W-1:0] req_gap,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_dec;
  logic [CNT_W-1:0] eoi_rem;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gcnt;
  logic             accept;
  logic             shift;
  logic             msb;
  logic             next_bit;
  logic             last;
  logic             eoi;
  logic             eoi_bit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;
  assign shift     = (state == SHIFT);
  assign rem_dec   = (rem == '0) ? '0 : rem - CNT_W'(1);

`ifdef PATTERN_TX_PARITY_EN
  logic par;
  assign eoi     = (state == PAR);
  assign eoi_rem = rem;
  assign eoi_bit = msb;
`else
  assign eoi     = shift && last;
  assign eoi_rem = rem_dec;
  assign eoi_bit = next_bit;
`endif

  pattern_tx_shifter #(
    .PAT_W(PAT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (shift),
    .pattern (req_pattern),
    .msb     (msb),
    .next_bit(next_bit),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      gap_len    <= '0;
      gcnt       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rem     <= req_repeat;
            gap_len <= req_gap;
`ifdef PATTERN_TX_PARITY_EN
            par     <= ^req_pattern;
`endif
            // zero repeats: one GAP cycle with rem==0 yields the done pulse
            if (req_repeat == '0) begin
              state <= GAP;
            end else begin
              state      <= SHIFT;
              dout       <= req_pattern[PAT_W-1];
              dout_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!last) begin
            dout       <= next_bit;
            dout_valid <= 1'b1;
          end else begin
            rem <= rem_dec;
`ifdef PATTERN_TX_PARITY_EN
            state      <= PAR;
            dout       <= par;
            dout_valid <= 1'b1;
`endif
          end
        end
        GAP: begin
          if (rem == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (gcnt == GAP_W'(1)) begin
            state      <= SHIFT;
            dout       <= msb;
            dout_valid <= 1'b1;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end
        default: ;
      endcase
      // end of instance overrides the per-state defaults above
      if (eoi) begin
        if (eoi_rem == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (gap_len == '0) begin
          state      <= SHIFT;
          dout       <= eoi_bit;
          dout_valid <= 1'b1;
        end else begin
          state <= GAP;
          gcnt  <= gap_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: model expands each request into cycles.
// Build with PATTERN_TX_PARITY_EN to exercise the parity variant.
module tb_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
`ifdef PATTERN_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  typedef struct packed {
    logic v;
    logic b;
    logic last;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [PAT_W-1:0] req_pattern = '0;
  logic [CNT_W-1:0] req_repeat = '0;
  logic [GAP_W-1:0] req_gap = '0;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   pend = 1'b0;
  ent_t q[$];
  ent_t e;

  pattern_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pattern(req_pattern),
    .req_repeat (req_repeat),
    .req_gap    (req_gap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One entry per busy cycle: PAT_W data bits, optional parity, gap idles.
  task automatic push_model(input logic [PAT_W-1:0] p, input int rep,
                            input int g);
    int n_tot;
    int k;
    n_tot = (rep == 0) ? 1 : rep * (PAT_W + PAR_EN) + (rep - 1) * g;
    k = 0;
    if (rep == 0) q.push_back('{1'b0, 1'b0, 1'b1});
    for (int n = 0; n < rep; n++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        k++;
        q.push_back('{1'b1, p[b], logic'(k == n_tot)});
      end
      if (PAR_EN != 0) begin
        k++;
        q.push_back('{1'b1, ^p, logic'(k == n_tot)});
      end
      if (n < rep - 1)
        for (int i = 0; i < g; i++) begin
          k++;
          q.push_back('{1'b0, 1'b0, 1'b0});
        end
    end
  endtask

  task automatic send(input logic [PAT_W-1:0] p, input int rep, input int g,
                      input bit hold);
    bit ok;
    ok = 1'b0;
    req_pattern = p;
    req_repeat  = CNT_W'(rep);
    req_gap     = GAP_W'(g);
    req_valid   = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else push_model(p, rep, g);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    if (ok) chk("accept_busy", busy, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (pend) begin
        chk("done_pulse", {busy, done, req_ready}, 3'b011);
        pend = 1'b0;
      end else if (done) begin
        chk("spurious_done", done, 0);
      end
      if (busy) begin
        if (q.size() == 0) begin
          chk("unexpected_busy", busy, 0);
        end else begin
          e = q.pop_front();
          chk("dout_valid", dout_valid, e.v);
          chk("dout", dout, e.b);
          if (e.last) pend = 1'b1;
        end
      end else begin
        chk("idle_out", {dout_valid, dout}, 0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {dout, dout_valid, done, busy}, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(4'b0110, 2, 0, 1'b0);
    send(4'b1011, 3, 2, 1'b0);
    send(4'b0101, 0, 0, 1'b0);
    send(4'b1100, 1, 1, 1'b1);
    send(4'b0011, 2, 1, 1'b1);
    send(4'b0111, 1, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      send(PAT_W'($urandom), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    req_valid = 1'b0;

    for (int i = 0; i < 200 && (q.size() != 0 || pend || busy); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", q.size() + int'(pend), 0);

    mon_en = 1'b0;
    send(4'b1011, 3, 1, 1'b0);
    @(negedge clk);
    chk("pre_rst_bit0", {dout_valid, dout}, 2'b11);
    @(negedge clk);
    chk("pre_rst_bit1", {dout_valid, dout}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {dout, dout_valid, busy, done}, 0);
    q.delete();
    pend = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {req_ready, busy, done}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
